// File: rtl/gear_pkg.sv
// Shared types and speed-window helpers for the clutch-handshaked gear selector.
package gear_pkg;

  typedef enum logic [1:0] {
    DRIVE      = 2'd0,
    DISENGAGED = 2'd1,
    SYNC       = 2'd2
  } state_e;

  localparam int unsigned NEUTRAL = 0;

  function automatic int unsigned vel_max(input int unsigned vel_w);
    return (32'd1 << vel_w) - 32'd1;
  endfunction

  // Lower window edge; gear 1 always starts at standstill.
  function automatic int unsigned win_lo(input int unsigned g, input int unsigned step,
                                         input int unsigned margin, input int unsigned vel_w);
    int unsigned lo;
    if (g <= 1 || step * (g - 1) <= margin) lo = 0;
    else                                    lo = step * (g - 1) - margin;
    return (lo > vel_max(vel_w)) ? vel_max(vel_w) : lo;
  endfunction

  // Upper window edge; the top gear is open-ended.
  function automatic int unsigned win_hi(input int unsigned g, input int unsigned num_gears,
                                         input int unsigned step, input int unsigned margin,
                                         input int unsigned vel_w);
    int unsigned hi;
    if (g >= num_gears) return vel_max(vel_w);
    hi = step * g + margin;
    return (hi > vel_max(vel_w)) ? vel_max(vel_w) : hi;
  endfunction

endpackage

// File: rtl/gear_window_chk.sv
// Combinational speed-window check for one gear code (neutral, forward or reverse).
module gear_window_chk
  import gear_pkg::*;
#(
  parameter int unsigned NUM_GEARS   = 5,
  parameter int unsigned VEL_W       = 8,
  parameter int unsigned GEAR_W      = 3,
  parameter int unsigned STEP        = 20,
  parameter int unsigned MARGIN      = 5,
  parameter int unsigned REV_CODE    = 6,
  parameter int unsigned REV_MAX_VEL = 5
) (
  input  logic [GEAR_W-1:0] gear_code,
  input  logic [VEL_W-1:0]  velocity,
  output logic              in_window
);

  logic [VEL_W-1:0] lo;
  logic [VEL_W-1:0] hi;
  logic             fwd;

  // Select the window bounds of the addressed forward gear, then compare once.
  always_comb begin
    lo  = '0;
    hi  = '0;
    fwd = 1'b0;
    for (int unsigned g = 1; g <= NUM_GEARS; g++) begin
      if (gear_code == GEAR_W'(g)) begin
        fwd = 1'b1;
        lo  = VEL_W'(win_lo(g, STEP, MARGIN, VEL_W));
        hi  = VEL_W'(win_hi(g, NUM_GEARS, STEP, MARGIN, VEL_W));
      end
    end
    in_window = 1'b0;
    if (gear_code == GEAR_W'(NEUTRAL))       in_window = 1'b1;
    else if (gear_code == GEAR_W'(REV_CODE)) in_window = (velocity <= VEL_W'(REV_MAX_VEL));
    else if (fwd)                            in_window = (velocity >= lo) && (velocity <= hi);
  end

endmodule

// File: rtl/gear_shift_ctrl.sv
// Gear selector: validates requests against speed windows, commits after a clutch
// release plus synchroniser delay, and flags sustained out-of-window driving.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int unsigned NUM_GEARS    = 5,
  parameter int unsigned VEL_W        = 8,
  parameter int unsigned GEAR_W       = 3,
  parameter int unsigned STEP         = 20,
  parameter int unsigned MARGIN       = 5,
  parameter int unsigned REV_CODE     = 6,
  parameter int unsigned REV_MAX_VEL  = 5,
  parameter int unsigned SHIFT_CYCLES = 4,
  parameter int unsigned ERR_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clutch,
  input  logic                 reverse,
  input  logic [NUM_GEARS-1:0] gear_req,
  input  logic [VEL_W-1:0]     velocity_in,
  output logic [GEAR_W-1:0]    gear,
  output logic                 shifting,
  output logic                 shift_done,
  output logic                 shift_rej,
  output logic                 window_err
);

  localparam int unsigned SC_W  = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;
  localparam int unsigned ERR_W = $clog2(ERR_CYCLES + 1);

  state_e              state_q, state_d;
  logic [GEAR_W-1:0]   gear_q, gear_d;
  logic [GEAR_W-1:0]   target_q, target_d;
  logic [SC_W-1:0]     sync_cnt_q, sync_cnt_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                shift_done_q, shift_done_d;
  logic                shift_rej_q, shift_rej_d;
  logic                window_err_q, window_err_d;
  logic                shifting_q, shifting_d;

  logic [GEAR_W-1:0]   req_code;
  logic                req_ok;
  logic                req_in_win;
  logic                cur_in_win;
  logic                gear_fwd;

  gear_window_chk #(
    .NUM_GEARS(NUM_GEARS), .VEL_W(VEL_W), .GEAR_W(GEAR_W), .STEP(STEP),
    .MARGIN(MARGIN), .REV_CODE(REV_CODE), .REV_MAX_VEL(REV_MAX_VEL)
  ) u_tgt_chk (
    .gear_code(req_code),
    .velocity (velocity_in),
    .in_window(req_in_win)
  );

  gear_window_chk #(
    .NUM_GEARS(NUM_GEARS), .VEL_W(VEL_W), .GEAR_W(GEAR_W), .STEP(STEP),
    .MARGIN(MARGIN), .REV_CODE(REV_CODE), .REV_MAX_VEL(REV_MAX_VEL)
  ) u_cur_chk (
    .gear_code(gear_q),
    .velocity (velocity_in),
    .in_window(cur_in_win)
  );

  // Request decode: reverse wins, multi-hot forward requests are invalid.
  always_comb begin
    req_code = GEAR_W'(NEUTRAL);
    req_ok   = 1'b1;
    if (reverse) begin
      req_code = GEAR_W'(REV_CODE);
    end else if (!$onehot0(gear_req)) begin
      req_ok = 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_GEARS; i++) begin
        if (gear_req[i]) req_code = GEAR_W'(i + 1);
      end
    end
  end

  assign gear_fwd = (gear_q != GEAR_W'(NEUTRAL)) && (gear_q <= GEAR_W'(NUM_GEARS));

  always_comb begin
    state_d      = state_q;
    gear_d       = gear_q;
    target_d     = target_q;
    sync_cnt_d   = sync_cnt_q;
    err_cnt_d    = '0;
    shift_done_d = 1'b0;
    shift_rej_d  = 1'b0;

    unique case (state_q)
      DRIVE: begin
        if (clutch) state_d = DISENGAGED;
      end
      DISENGAGED: begin
        if (req_ok) target_d = req_code;
        if (!clutch) begin
          if (req_ok && req_in_win) begin
            state_d    = SYNC;
            sync_cnt_d = SC_W'(SHIFT_CYCLES - 1);
          end else begin
            state_d     = DRIVE;
            shift_rej_d = 1'b1;
          end
        end
      end
      SYNC: begin
        if (clutch) begin
          state_d = DISENGAGED;
        end else if (sync_cnt_q == '0) begin
          state_d      = DRIVE;
          gear_d       = target_q;
          shift_done_d = 1'b1;
        end else begin
          sync_cnt_d = sync_cnt_q - SC_W'(1);
        end
      end
      default: state_d = DRIVE;
    endcase

    // Out-of-window persistence only counts while cruising in a forward gear.
    if (state_q == DRIVE && state_d == DRIVE && gear_fwd && !cur_in_win) begin
      err_cnt_d = (err_cnt_q >= ERR_W'(ERR_CYCLES)) ? err_cnt_q : err_cnt_q + ERR_W'(1);
    end
    window_err_d = (err_cnt_d >= ERR_W'(ERR_CYCLES));
    shifting_d   = (state_d != DRIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= DRIVE;
      gear_q       <= '0;
      target_q     <= '0;
      sync_cnt_q   <= '0;
      err_cnt_q    <= '0;
      shift_done_q <= 1'b0;
      shift_rej_q  <= 1'b0;
      window_err_q <= 1'b0;
      shifting_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gear_q       <= gear_d;
      target_q     <= target_d;
      sync_cnt_q   <= sync_cnt_d;
      err_cnt_q    <= err_cnt_d;
      shift_done_q <= shift_done_d;
      shift_rej_q  <= shift_rej_d;
      window_err_q <= window_err_d;
      shifting_q   <= shifting_d;
    end
  end

  assign gear       = gear_q;
  assign shifting   = shifting_q;
  assign shift_done = shift_done_q;
  assign shift_rej  = shift_rej_q;
  assign window_err = window_err_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed plus randomized bench for gear_shift_ctrl (default and 7-gear configurations).
module tb_gear_shift_ctrl;

  localparam int SHIFT = 4;
  localparam int ERR   = 8;

  logic       clk;
  logic       rst;
  logic       clutch;
  logic       reverse;
  logic [4:0] gear_req_a;
  logic [6:0] gear_req_b;
  logic [7:0] velocity;
  logic [2:0] gear_a;
  logic [3:0] gear_b;
  logic       shifting_a, shift_done_a, shift_rej_a, window_err_a;
  logic       shifting_b, shift_done_b, shift_rej_b, window_err_b;

  gear_shift_ctrl dut (
    .clk(clk), .rst(rst), .clutch(clutch), .reverse(reverse),
    .gear_req(gear_req_a), .velocity_in(velocity), .gear(gear_a),
    .shifting(shifting_a), .shift_done(shift_done_a), .shift_rej(shift_rej_a),
    .window_err(window_err_a)
  );

  gear_shift_ctrl #(.NUM_GEARS(7), .STEP(15), .GEAR_W(4), .REV_CODE(8)) dut7 (
    .clk(clk), .rst(rst), .clutch(clutch), .reverse(reverse),
    .gear_req(gear_req_b), .velocity_in(velocity), .gear(gear_b),
    .shifting(shifting_b), .shift_done(shift_done_b), .shift_rej(shift_rej_b),
    .window_err(window_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Active configuration and abstract model state
  bit sel = 1'b0;
  int c_ng   = 5;
  int c_step = 20;
  int c_rev  = 6;
  int exp_gear = 0;
  int m_err    = 0;

  logic [3:0] o_gear;
  logic       o_shifting, o_done, o_rej, o_err;

  always_comb begin
    if (sel) begin
      o_gear = gear_b; o_shifting = shifting_b; o_done = shift_done_b;
      o_rej = shift_rej_b; o_err = window_err_b;
    end else begin
      o_gear = {1'b0, gear_a}; o_shifting = shifting_a; o_done = shift_done_a;
      o_rej = shift_rej_a; o_err = window_err_a;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int m_decode(input bit rev, input int unsigned req);
    int n, idx;
    n = 0; idx = 0;
    if (rev) return c_rev;
    for (int i = 0; i < c_ng; i++) if (req[i]) begin n++; idx = i + 1; end
    if (n == 0) return 0;
    if (n == 1) return idx;
    return -1;
  endfunction

  function automatic bit m_in_win(input int code, input int v);
    int lo, hi;
    if (code == 0) return 1'b1;
    if (code == c_rev) return (v <= 5);
    if (code < 1 || code > c_ng) return 1'b0;
    lo = (code == 1) ? 0 : c_step * (code - 1) - 5;
    if (lo < 0) lo = 0;
    hi = (code == c_ng) ? 255 : c_step * code + 5;
    if (hi > 255) hi = 255;
    return (v >= lo) && (v <= hi);
  endfunction

  task automatic set_req(input int unsigned r);
    if (sel) begin gear_req_b = 7'(r); gear_req_a = '0; end
    else     begin gear_req_a = 5'(r); gear_req_b = '0; end
  endtask

  // One cruising cycle; tracks the sustained out-of-window count.
  task automatic drive_tick(input int v);
    velocity = 8'(v);
    tick();
    if (exp_gear >= 1 && exp_gear <= c_ng) begin
      if (!m_in_win(exp_gear, v)) m_err = (m_err < ERR) ? m_err + 1 : ERR;
      else                        m_err = 0;
    end else m_err = 0;
    chk("drive_gear", 32'(o_gear), 32'(exp_gear));
    chk("drive_window_err", 32'(o_err), 32'(m_err >= ERR));
    chk("drive_no_pulse", 32'({o_done, o_rej}), 32'(0));
  endtask

  // Full clutch press/release transaction; only the final request is meaningful.
  task automatic do_shift(input bit rev, input int unsigned req, input int v, input int hold);
    int code;
    bit ok;
    code = m_decode(rev, req);
    ok   = (code >= 0) && m_in_win(code, v);
    clutch   = 1'b1;
    velocity = 8'(v);
    for (int h = 0; h < hold; h++) begin
      if (h < hold - 1) begin
        reverse = 1'($urandom_range(0, 1));
        set_req($urandom_range(0, (1 << c_ng) - 1));
      end else begin
        reverse = rev;
        set_req(req);
      end
      tick();
      chk("press_shifting", 32'(o_shifting), 32'(1));
      chk("press_gear", 32'(o_gear), 32'(exp_gear));
      chk("press_window_err", 32'(o_err), 32'(0));
      chk("press_no_pulse", 32'({o_done, o_rej}), 32'(0));
    end
    m_err  = 0;
    clutch = 1'b0;
    tick();
    if (!ok) begin
      chk("rej_pulse", 32'(o_rej), 32'(1));
      chk("rej_shifting", 32'(o_shifting), 32'(0));
      chk("rej_gear", 32'(o_gear), 32'(exp_gear));
    end else begin
      chk("release_no_rej", 32'(o_rej), 32'(0));
      chk("release_shifting", 32'(o_shifting), 32'(1));
      for (int k = 1; k < SHIFT; k++) begin
        velocity = 8'($urandom_range(0, 255));
        tick();
        chk("sync_gear_held", 32'(o_gear), 32'(exp_gear));
        chk("sync_no_done", 32'(o_done), 32'(0));
        chk("sync_shifting", 32'(o_shifting), 32'(1));
      end
      tick();
      exp_gear = code;
      chk("commit_gear", 32'(o_gear), 32'(exp_gear));
      chk("commit_done", 32'(o_done), 32'(1));
      chk("commit_shifting", 32'(o_shifting), 32'(0));
    end
    reverse = 1'b0;
    set_req(0);
    drive_tick(v);
  endtask

  task automatic random_shift();
    int kind, b1, b2, v;
    bit rev;
    int unsigned req;
    kind = $urandom_range(0, 9);
    rev  = (kind == 0);
    if (kind == 1) req = 0;
    else if (kind == 2) begin
      b1  = $urandom_range(0, c_ng - 1);
      b2  = (b1 + 1 + $urandom_range(0, c_ng - 2)) % c_ng;
      req = (1 << b1) | (1 << b2);
    end else req = 1 << $urandom_range(0, c_ng - 1);
    v = rev ? $urandom_range(0, 9) : $urandom_range(0, c_step * c_ng + 20);
    do_shift(rev, req, v, $urandom_range(1, 3));
    for (int i = 0; i < $urandom_range(0, 12); i++)
      drive_tick((i % 2 == 0) ? v : $urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b0; clutch = 1'b0; reverse = 1'b0;
    gear_req_a = '0; gear_req_b = '0; velocity = '0;
    tick(); tick();
    chk("reset_gear", 32'(o_gear), 32'(0));
    chk("reset_shifting", 32'(o_shifting), 32'(0));
    chk("reset_pulses", 32'({o_done, o_rej, o_err}), 32'(0));
    chk("reset_gear7", 32'(gear_b), 32'(0));
    rst = 1'b1;
    drive_tick(10);

    // Basic shift into first gear
    do_shift(1'b0, 5'b00001, 10, 1);
    chk("first_gear", 32'(gear_a), 32'(1));

    // Out-of-window and in-window requests for gear 5
    do_shift(1'b0, 5'b10000, 50, 2);
    chk("g5_rejected", 32'(gear_a), 32'(1));
    do_shift(1'b0, 5'b10000, 80, 2);
    chk("g5_engaged", 32'(gear_a), 32'(5));

    // Reverse limits and multi-bit request
    do_shift(1'b1, 5'b00000, 5, 1);
    chk("reverse_engaged", 32'(gear_a), 32'(6));
    do_shift(1'b1, 5'b00000, 6, 1);
    do_shift(1'b0, 5'b00110, 20, 1);
    chk("multi_rejected", 32'(gear_a), 32'(6));

    // Window boundaries of gears 2 and 3
    do_shift(1'b0, 5'b00010, 14, 1);
    do_shift(1'b0, 5'b00010, 45, 1);
    do_shift(1'b0, 5'b00100, 34, 1);
    do_shift(1'b0, 5'b00100, 35, 1);
    chk("boundary_gear3", 32'(gear_a), 32'(3));

    // Aborted synchronisation restarts the full delay
    clutch = 1'b1; set_req(5'b00010); velocity = 8'd20;
    tick();
    clutch = 1'b0;
    tick(); tick(); tick();
    chk("abort_sync_shifting", 32'(o_shifting), 32'(1));
    clutch = 1'b1;
    tick();
    chk("abort_shifting", 32'(o_shifting), 32'(1));
    chk("abort_no_done", 32'(o_done), 32'(0));
    chk("abort_gear", 32'(o_gear), 32'(3));
    do_shift(1'b0, 5'b00010, 20, 1);
    chk("after_abort_gear", 32'(gear_a), 32'(2));

    // Sustained out-of-window operation in gear 2
    for (int i = 0; i < ERR - 1; i++) drive_tick(60);
    chk("err_not_yet", 32'(window_err_a), 32'(0));
    drive_tick(60);
    chk("err_asserted", 32'(window_err_a), 32'(1));
    drive_tick(30);
    chk("err_cleared_vel", 32'(window_err_a), 32'(0));
    for (int i = 0; i < ERR + 1; i++) drive_tick(60);
    chk("err_reasserted", 32'(window_err_a), 32'(1));
    do_shift(1'b0, 5'b00010, 30, 1);

    for (int n = 0; n < 40; n++) random_shift();

    // Reset in the middle of a synchronisation
    do_shift(1'b0, 5'b00100, 50, 1);
    chk("pre_reset_gear3", 32'(gear_a), 32'(3));
    clutch = 1'b1; set_req(5'b01000); velocity = 8'd60;
    tick();
    clutch = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("midsync_reset_gear", 32'(gear_a), 32'(0));
    chk("midsync_reset_shifting", 32'(shifting_a), 32'(0));
    chk("midsync_reset_pulses", 32'({shift_done_a, shift_rej_a, window_err_a}), 32'(0));
    rst = 1'b1; set_req(0);
    exp_gear = 0; m_err = 0;
    drive_tick(60);

    // Seven-gear configuration
    sel = 1'b1; c_ng = 7; c_step = 15; c_rev = 8;
    set_req(0);
    chk("cfg7_reset_gear", 32'(gear_b), 32'(0));
    do_shift(1'b0, 7'b1000000, 84, 1);
    do_shift(1'b0, 7'b0000010, 36, 1);
    do_shift(1'b0, 7'b0000010, 10, 1);
    chk("cfg7_gear2", 32'(gear_b), 32'(2));
    do_shift(1'b0, 7'b1000000, 200, 2);
    chk("cfg7_top_gear", 32'(gear_b), 32'(7));
    do_shift(1'b1, 7'b0000000, 3, 1);
    chk("cfg7_reverse", 32'(gear_b), 32'(8));
    for (int n = 0; n < 25; n++) random_shift();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
